ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//  PS/2 device-to-host frame receiver and scancode event decoder; upstream stage of the PS2->matrix keyboard map.
//  Samples kclk/kdat, deframes 11-bit frames, folds E0/F0 prefixes into flags, buffers {ext,rel,code} events in a FIFO.
//  Downstream pops with a valid/ready handshake; one event per key make/break.
// PARAMETERS
//  SYNC_STAGES  2   flops in kclk/kdat synchronizers (>=2)
//  TOUT_BITS    12  width of inter-edge timeout counter; abort at 2**TOUT_BITS-1 clk without kclk fall
//  FIFO_DEPTH   4   event FIFO entries (power of 2, >=2)
// PORTS
//  clk      in   1   system clock (CPU clock); sole clock
//  rst      in   1   synchronous, active-high reset
//  kclk     in   1   PS/2 clock, asynchronous
//  kdat     in   1   PS/2 data, asynchronous
//  evt_code out  8   scancode of head event
//  evt_rel  out  1   1 = break (F0 prefix seen)
//  evt_ext  out  1   1 = extended (E0 prefix seen)
//  evt_vld  out  1   FIFO not empty
//  evt_rdy  in   1   consumer pops head when evt_vld&evt_rdy
//  overrun  out  1   1-cycle pulse: decoded event dropped, FIFO full
//  perr     out  1   1-cycle pulse: parity or stop-bit error, frame dropped
// BEHAVIOUR
//  Reset (clk edge with rst=1): FSM IDLE, bit count 0, timeout 0, prefix flags 0, FIFO empty;
//   evt_vld=0, evt_code=0, evt_rel=0, evt_ext=0, overrun=0, perr=0. Reset mid-frame discards the partial frame.
//  fall = synchronized kclk was 1 last cycle and is 0 now; kdat sampled (synchronized) in that cycle.
//  FSM: IDLE --fall&kdat=0--> DATA (fall&kdat=1 ignored, stays IDLE).
//   DATA: shift kdat in LSB first; after 8th fall -> PARITY. PARITY: store bit -> STOP.
//   STOP: on fall, frame complete -> IDLE; good frame iff kdat=1 and data+parity has odd number of 1s.
//  Timeout: counter cleared on every fall, else increments (saturates); reaching all-ones in non-IDLE state -> IDLE,
//   frame discarded, no perr.
//  Prefix stage (good byte, registered, cycle N+1 after stop fall at cycle N):
//   0xE0 -> ext flag=1, no push; 0xF0 -> rel flag=1, no push; 0xE1, 0x00, 0xFF -> dropped, flags unchanged;
//   any other byte -> push {ext,rel,byte}, clear both flags.
//  Latency: evt_vld rises in cycle N+2 when FIFO was empty. Bad frame: perr high in cycle N+1; flags unchanged.
//  FIFO: push on full -> event lost, overrun pulse, flags cleared. Push and pop same cycle when full -> both succeed.
//   Head outputs stable while evt_vld&~evt_rdy. Order strictly preserved; pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  PS2_PARITY_CHK_EN defined: parity/stop checked as above, perr driven.
//  Undefined: parity and stop bit ignored, every completed frame is good, perr tied 0.
// STRUCTURE
//  ps2_defs.vh: FSM state localparams (IDLE/DATA/PARITY/STOP), PS2_PFX_EXT=8'hE0, PS2_PFX_REL=8'hF0,
//   PS2_PAUSE=8'hE1, event width EVT_W=10 and field offsets.
//  Sub-module ps2_evt_fifo: synchronous FIFO, EVT_W x FIFO_DEPTH, push/pop/full/empty.
// TESTING
//  1 Frame 0x1C, parity 0, stop 1, ~80us bit period -> one event code=1C rel=0 ext=0; evt_vld N+2.
//  2 Frames F0,1C -> single event code=1C rel=1 ext=0; no event for F0.
//  3 Frames E0,F0,75 -> single event code=75 rel=1 ext=1; next frame 75 -> rel=0 ext=0.
//  4 0x1C with parity bit 1: macro on -> perr pulse, no event; macro off -> event code=1C.
//  5 Start + 4 data bits, idle 2**TOUT_BITS clk, then frame 0x29 -> exactly one event code=29.
//  6 evt_rdy=0, send 16,1E,26,25,2E (depth 4) -> overrun pulse once; rdy=1 pops 16,1E,26,25 in order.

Source files
------------

// File: rtl/ps2_scancode_rx_pkg.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx_pkg
// Shared definitions for the PS/2 scancode receiver: frame FSM state encoding,
// scancode prefix bytes, event word layout and a small byte-class helper.
// Event word layout (EVT_W bits): {ext, rel, code[7:0]}.
// ----------------------------------------------------------------------------
package ps2_scancode_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2State_t;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;
    localparam logic [7:0] PS2_PAUSE   = 8'hE1;

    localparam int EVT_W        = 10;
    localparam int EVT_CODE_LSB = 0;
    localparam int EVT_REL_BIT  = 8;
    localparam int EVT_EXT_BIT  = 9;

    // Bytes that carry no key event of their own and leave prefix flags alone
    function automatic logic isDroppedByte(input logic [7:0] b);
        return (b == PS2_PAUSE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_evt_fifo.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx_evt_fifo
// Synchronous event FIFO, EVT_W bits x DEPTH entries (DEPTH power of 2, >=2).
// Ports:
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_push/i_data write request and event word
//   i_pop         read request (ignored while empty)
//   o_data        head entry
//   o_full/o_empty status
// A push while full is accepted only if a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module ps2_scancode_rx_evt_fifo
    import ps2_scancode_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [EVT_W-1:0] i_data,
    input  logic             i_pop,
    output logic [EVT_W-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [EVT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_CNT);
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);
    assign o_data   = r_mem[r_rdPtr];

    // Storage needs no reset: the head is only meaningful while not empty
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx
// PS/2 device-to-host frame receiver and scancode event decoder.
// Synchronizes kclk/kdat, deframes 11-bit frames on kclk falling edges, folds
// E0/F0 prefixes into ext/rel flags and queues {ext,rel,code} events.
// Ports:
//   i_clk, i_rst       system clock, synchronous active-high reset
//   i_kclk, i_kdat     asynchronous PS/2 clock and data
//   o_evt_code/rel/ext head event fields (zero while FIFO empty)
//   o_evt_vld, i_evt_rdy  valid/ready pop handshake
//   o_overrun          1-cycle pulse when an event is lost to a full FIFO
//   o_perr             1-cycle pulse on parity/stop error
// Build option: define PS2_PARITY_CHK_EN to check parity and stop bit and
// drive o_perr; otherwise every completed frame is accepted and o_perr is 0.
// ----------------------------------------------------------------------------
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TOUT_BITS   = 12,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_kclk,
    input  logic       i_kdat,
    output logic [7:0] o_evt_code,
    output logic       o_evt_rel,
    output logic       o_evt_ext,
    output logic       o_evt_vld,
    input  logic       i_evt_rdy,
    output logic       o_overrun,
    output logic       o_perr
);

    localparam logic [TOUT_BITS-1:0] TOUT_ONE = 1;

    logic [SYNC_STAGES-1:0] r_kclkSync;
    logic [SYNC_STAGES-1:0] r_kdatSync;
    logic                   r_kclkPrev;
    logic                   w_kclk;
    logic                   w_kdat;
    logic                   w_fall;

    ps2State_t              r_state;
    logic [2:0]             r_bitCnt;
    logic [7:0]             r_shift;
    logic [TOUT_BITS-1:0]   r_tout;
    logic                   r_frmVld;
    logic [7:0]             r_frmByte;
`ifdef PS2_PARITY_CHK_EN
    logic                   r_par;
    logic                   r_perr;
`endif

    logic                   r_ext;
    logic                   r_rel;
    logic                   r_overrun;
    logic                   w_isExt;
    logic                   w_isRel;
    logic                   w_push;
    logic [EVT_W-1:0]       w_pushData;
    logic [EVT_W-1:0]       w_head;
    logic                   w_full;
    logic                   w_empty;

    // Synchronizers preset high so reset never manufactures a kclk fall
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_kclkSync <= '1;
            r_kdatSync <= '1;
            r_kclkPrev <= 1'b1;
        end else begin
            r_kclkSync <= {r_kclkSync[SYNC_STAGES-2:0], i_kclk};
            r_kdatSync <= {r_kdatSync[SYNC_STAGES-2:0], i_kdat};
            r_kclkPrev <= w_kclk;
        end
    end

    assign w_kclk = r_kclkSync[SYNC_STAGES-1];
    assign w_kdat = r_kdatSync[SYNC_STAGES-1];
    assign w_fall = r_kclkPrev & ~w_kclk;

    // Frame FSM. Every kclk fall advances one bit; a stall long enough for
    // the timeout counter to saturate abandons a partial frame silently.
    // A completed good frame is presented for one cycle in r_frmByte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_bitCnt  <= 3'd0;
            r_shift   <= 8'h00;
            r_tout    <= '0;
            r_frmVld  <= 1'b0;
            r_frmByte <= 8'h00;
`ifdef PS2_PARITY_CHK_EN
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_frmVld <= 1'b0;
`ifdef PS2_PARITY_CHK_EN
            r_perr   <= 1'b0;
`endif
            if (w_fall) begin
                r_tout <= '0;
            end else if (r_tout != '1) begin
                r_tout <= r_tout + TOUT_ONE;
            end

            if (!w_fall && (r_state != ST_IDLE) && (r_tout == '1)) begin
                r_state <= ST_IDLE;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_kdat) begin
                            r_state  <= ST_DATA;
                            r_bitCnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {w_kdat, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHK_EN
                        r_par   <= w_kdat;
`endif
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
`ifdef PS2_PARITY_CHK_EN
                        if (w_kdat && (^{r_shift, r_par})) begin
                            r_frmVld  <= 1'b1;
                            r_frmByte <= r_shift;
                        end else begin
                            r_perr <= 1'b1;
                        end
`else
                        r_frmVld  <= 1'b1;
                        r_frmByte <= r_shift;
`endif
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef PS2_PARITY_CHK_EN
    assign o_perr = r_perr;
`else
    assign o_perr = 1'b0;
`endif

    // Prefix classification of the byte just received
    always_comb begin
        w_isExt    = (r_frmByte == PS2_PFX_EXT);
        w_isRel    = (r_frmByte == PS2_PFX_REL);
        w_push     = r_frmVld & ~w_isExt & ~w_isRel & ~isDroppedByte(r_frmByte);
        w_pushData = '0;
        w_pushData[EVT_EXT_BIT]            = r_ext;
        w_pushData[EVT_REL_BIT]            = r_rel;
        w_pushData[EVT_CODE_LSB +: 8]      = r_frmByte;
    end

    // Prefix flags accumulate until a real scancode consumes them, even if
    // that scancode is then lost to a full FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push & w_full & ~i_evt_rdy;
            if (r_frmVld) begin
                if (w_isExt) begin
                    r_ext <= 1'b1;
                end else if (w_isRel) begin
                    r_rel <= 1'b1;
                end else if (w_push) begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                end
            end
        end
    end

    assign o_overrun = r_overrun;

    ps2_scancode_rx_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_pushData),
        .i_pop   (i_evt_rdy),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head fields read as zero while nothing is queued
    assign o_evt_vld  = ~w_empty;
    assign o_evt_code = w_head[EVT_CODE_LSB +: 8] & {8{~w_empty}};
    assign o_evt_rel  = w_head[EVT_REL_BIT] & ~w_empty;
    assign o_evt_ext  = w_head[EVT_EXT_BIT] & ~w_empty;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scancode_rx
// Self-checking bench for ps2_scancode_rx: drives PS/2 frames bit by bit and
// compares popped events against a byte-level model of the prefix rules.
// ----------------------------------------------------------------------------
module tb_ps2_scancode_rx;

    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 4;
`ifdef PS2_PARITY_CHK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       kclk;
    logic       kdat;
    logic       evtRdy;
    logic [7:0] evtCode;
    logic       evtRel;
    logic       evtExt;
    logic       evtVld;
    logic       overrun;
    logic       perr;

    int total = 0;
    int bad   = 0;
    int ovrSeen = 0;
    int perrSeen = 0;
    int ovrExp = 0;
    int perrExp = 0;

    logic [9:0] expQ[$];
    logic       modelExt;
    logic       modelRel;

    always #5 clk = ~clk;

    ps2_scancode_rx dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_kclk     (kclk),
        .i_kdat     (kdat),
        .o_evt_code (evtCode),
        .o_evt_rel  (evtRel),
        .o_evt_ext  (evtExt),
        .o_evt_vld  (evtVld),
        .i_evt_rdy  (evtRdy),
        .o_overrun  (overrun),
        .o_perr     (perr)
    );

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (overrun) ovrSeen++;
        if (perr)    perrSeen++;
    end

    function automatic logic [10:0] mkFrame(input logic [7:0] b, input bit badPar);
        logic p;
        p = (~^b) ^ badPar;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Reference: prefix folding and capacity, with consumer stalled
    task automatic modelByte(input logic [7:0] b);
        if (b == 8'hE0) modelExt = 1'b1;
        else if (b == 8'hF0) modelRel = 1'b1;
        else if (b == 8'hE1 || b == 8'h00 || b == 8'hFF) begin end
        else begin
            if (expQ.size() < DEPTH) expQ.push_back({modelExt, modelRel, b});
            else ovrExp++;
            modelExt = 1'b0;
            modelRel = 1'b0;
        end
    endtask

    task automatic sendBits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            int h;
            h = 15 + $urandom_range(0, 10);
            @(negedge clk);
            kdat = f[i];
            repeat (h) @(negedge clk);
            kclk = 1'b0;
            repeat (h) @(negedge clk);
            kclk = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit badPar);
        sendBits(mkFrame(b, badPar), 11);
        repeat (10) @(negedge clk);
    endtask

    task automatic popEvent(output logic [9:0] ev, output bit got);
        got = 1'b0;
        ev  = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (evtVld) got = 1'b1;
        end
        if (got) begin
            ev = {evtExt, evtRel, evtCode};
            evtRdy = 1'b1;
            @(negedge clk);
            evtRdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [9:0] ev;
        bit got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({evtVld, evtCode, evtRel, evtExt, overrun, perr} !== 13'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b want=0", {evtVld, evtCode, evtRel, evtExt, overrun, perr});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(8'hE0, 1'b0);
        sendBits(mkFrame(8'h55, 1'b0), 5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelExt = 1'b0;
        modelRel = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(8'h1C, 1'b0);
        popEvent(ev, got);
        total++;
        if (!got || ev !== {2'b00, 8'h1C}) begin
            bad++;
            $display("[TB] FAIL reset_midframe got=%h vld=%0d want=01c", ev, got);
        end
        repeat (20) @(negedge clk);
        total++;
        if (evtVld !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_extra_event got=%b want=0", evtVld);
        end
    endtask

    task automatic test_single();
        logic [9:0] ev;
        bit got;
        int firstK;
        sendBits(mkFrame(8'h1C, 1'b0), 10);
        @(negedge clk);
        kdat = 1'b1;
        repeat (20) @(negedge clk);
        kclk = 1'b0;
        firstK = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (evtVld && firstK < 0) firstK = k;
        end
        total++;
        if (firstK != SYNC_STAGES + 2) begin
            bad++;
            $display("[TB] FAIL single_latency got=%0d want=%0d", firstK, SYNC_STAGES + 2);
        end
        repeat (15) @(negedge clk);
        kclk = 1'b1;
        popEvent(ev, got);
        total++;
        if (!got || ev !== {2'b00, 8'h1C}) begin
            bad++;
            $display("[TB] FAIL single_event got=%h vld=%0d want=01c", ev, got);
        end
    endtask

    task automatic test_sequence(input string name, input logic [7:0] b0,
                                 input logic [7:0] b1, input logic [7:0] b2, input int n);
        logic [9:0] ev;
        logic [9:0] want;
        bit got;
        logic [7:0] seq [3];
        seq[0] = b0; seq[1] = b1; seq[2] = b2;
        for (int i = 0; i < n; i++) begin
            applyStimulus(seq[i], 1'b0);
            modelByte(seq[i]);
        end
        while (expQ.size() > 0) begin
            want = expQ.pop_front();
            popEvent(ev, got);
            total++;
            if (!got || ev !== want) begin
                bad++;
                $display("[TB] FAIL %s_event got=%h vld=%0d want=%h", name, ev, got, want);
            end
        end
        repeat (20) @(negedge clk);
        total++;
        if (evtVld !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_extra got=%b want=0", name, evtVld);
        end
    endtask

    task automatic test_break();
        test_sequence("break", 8'hF0, 8'h1C, 8'h00, 2);
    endtask

    task automatic test_extended();
        test_sequence("ext", 8'hE0, 8'hF0, 8'h75, 3);
        test_sequence("ext_next", 8'h75, 8'h00, 8'h00, 1);
    endtask

    task automatic test_parity();
        logic [9:0] ev;
        bit got;
        int perrBefore;
        perrBefore = perrSeen;
        applyStimulus(8'h1C, 1'b1);
        if (PAR_CHK) perrExp++;
        else modelByte(8'h1C);
        total++;
        if (perrSeen - perrBefore != (PAR_CHK ? 1 : 0)) begin
            bad++;
            $display("[TB] FAIL parity_perr got=%0d want=%0d", perrSeen - perrBefore, PAR_CHK ? 1 : 0);
        end
        if (expQ.size() > 0) begin
            popEvent(ev, got);
            total++;
            if (!got || ev !== expQ.pop_front()) begin
                bad++;
                $display("[TB] FAIL parity_event got=%h vld=%0d want=01c", ev, got);
            end
        end
        repeat (20) @(negedge clk);
        total++;
        if (evtVld !== 1'b0) begin
            bad++;
            $display("[TB] FAIL parity_extra got=%b want=0", evtVld);
        end
    endtask

    task automatic test_timeout();
        sendBits(mkFrame(8'h33, 1'b0), 5);
        repeat (4200) @(negedge clk);
        test_sequence("timeout", 8'h29, 8'h00, 8'h00, 1);
    endtask

    task automatic test_overrun();
        logic [7:0] bytesIn [5];
        logic [9:0] ev;
        logic [9:0] want;
        logic [7:0] headA;
        bit got;
        int ovrBefore;
        bytesIn[0] = 8'h16; bytesIn[1] = 8'h1E; bytesIn[2] = 8'h26;
        bytesIn[3] = 8'h25; bytesIn[4] = 8'h2E;
        ovrBefore = ovrSeen;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(bytesIn[i], 1'b0);
            modelByte(bytesIn[i]);
        end
        total++;
        if (ovrSeen - ovrBefore != 1) begin
            bad++;
            $display("[TB] FAIL overrun_pulses got=%0d want=1", ovrSeen - ovrBefore);
        end
        headA = evtCode;
        repeat (8) @(negedge clk);
        total++;
        if (evtCode !== expQ[0][7:0] || headA !== expQ[0][7:0]) begin
            bad++;
            $display("[TB] FAIL overrun_head_stable got=%h/%h want=%h", headA, evtCode, expQ[0][7:0]);
        end
        while (expQ.size() > 0) begin
            want = expQ.pop_front();
            popEvent(ev, got);
            total++;
            if (!got || ev !== want) begin
                bad++;
                $display("[TB] FAIL overrun_order got=%h vld=%0d want=%h", ev, got, want);
            end
        end
        repeat (20) @(negedge clk);
        total++;
        if (evtVld !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overrun_extra got=%b want=0", evtVld);
        end
    endtask

    task automatic test_random();
        logic [9:0] ev;
        logic [9:0] want;
        logic [7:0] b;
        bit got;
        bit badPar;
        int n;
        int sel;
        for (int batch = 0; batch < 4; batch++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                sel = $urandom_range(0, 99);
                if (sel < 20) b = 8'hE0;
                else if (sel < 35) b = 8'hF0;
                else b = 8'($urandom_range(0, 255));
                badPar = ($urandom_range(0, 9) == 0);
                applyStimulus(b, badPar);
                if (badPar && PAR_CHK) perrExp++;
                else modelByte(b);
            end
            while (expQ.size() > 0) begin
                want = expQ.pop_front();
                popEvent(ev, got);
                total++;
                if (!got || ev !== want) begin
                    bad++;
                    $display("[TB] FAIL random_event batch=%0d got=%h vld=%0d want=%h", batch, ev, got, want);
                end
            end
            repeat (20) @(negedge clk);
            total++;
            if (evtVld !== 1'b0) begin
                bad++;
                $display("[TB] FAIL random_extra batch=%0d got=%b want=0", batch, evtVld);
            end
        end
        total++;
        if (ovrSeen != ovrExp || perrSeen != perrExp) begin
            bad++;
            $display("[TB] FAIL pulse_totals overrun=%0d/%0d perr=%0d/%0d", ovrSeen, ovrExp, perrSeen, perrExp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        kclk     = 1'b1;
        kdat     = 1'b1;
        evtRdy   = 1'b0;
        modelExt = 1'b0;
        modelRel = 1'b0;
        test_reset();
        test_single();
        test_break();
        test_extended();
        test_parity();
        test_timeout();
        test_overrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
